// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit seven-segment scanner between four 32-bit debug sources.
// Auto mode rotates round-robin with a fixed dwell; manual mode follows man_sel; hold freezes the display.
module seg_display_arbiter #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] src_data,
  input  logic         mode,
  input  logic [1:0]   man_sel,
  input  logic         hold,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_src,
  output logic [3:0]   grant,
  output logic         disp_valid,
  output logic         switch_pulse
);

  // Handshake: there is none; req is a level request and grant is a level
  // acknowledge, both sampled/updated on the rising clk edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         src_q, src_d;
  logic [3:0]         grant_q, grant_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               pulse_q, pulse_d;
  logic               mode_q;

  logic               win_valid;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic               dwell_done;
  logic               rearb;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] i);
    return d[{i, 5'b0} +: 32];
  endfunction

  // Winner search: manual picks man_sel if it is requesting; auto scans from
  // the source after the last auto winner, wrapping, first requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    if (mode) begin
      win_valid = req[man_sel];
      win_idx   = man_sel;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = ptr_q + 2'(k);
        if (!win_valid && req[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign dwell_done = !mode && (cnt_q == CNT_W'(DWELL_CYCLES - 1));
  assign rearb      = dwell_done || !req[src_q] || (mode != mode_q) ||
                      (mode && (man_sel != src_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = SHOW;
          src_d   = win_idx;
          grant_d = onehot(win_idx);
          data_d  = word_of(src_data, win_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
          pulse_d = 1'b1;
          if (!mode) ptr_d = win_idx;
        end
      end
      SHOW: begin
        if (hold) begin
          state_d = FROZEN;
        end else if (rearb) begin
          cnt_d = '0;
          if (win_valid) begin
            src_d   = win_idx;
            grant_d = onehot(win_idx);
            data_d  = word_of(src_data, win_idx);
            pulse_d = (win_idx != src_q);
            if (!mode) ptr_d = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            data_d  = 32'h0;
            valid_d = 1'b0;
          end
        end else begin
          // Manual mode never expires, so its counter is parked at zero.
          cnt_d  = mode ? '0 : cnt_q + CNT_W'(1);
          data_d = word_of(src_data, src_q);
        end
      end
      FROZEN: begin
        if (!hold) begin
          state_d = SHOW;
          cnt_d   = '0;
          data_d  = word_of(src_data, src_q);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        data_d  = 32'h0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      src_q   <= 2'd0;
      grant_q <= 4'b0000;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      mode_q  <= mode;
    end
  end

  assign disp_data    = data_q;
  assign disp_src     = src_q;
  assign grant        = grant_q;
  assign disp_valid   = valid_q;
  assign switch_pulse = pulse_q;

  a_grant_matches_src: assert property (@(posedge clk) disable iff (rst)
    disp_valid |-> (grant == onehot(disp_src)));
  a_grant_zero_idle: assert property (@(posedge clk) disable iff (rst)
    !disp_valid |-> (grant == 4'b0000));
  a_pulse_only_valid: assert property (@(posedge clk) disable iff (rst)
    switch_pulse |-> disp_valid);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed table-driven bench for seg_display_arbiter with DWELL_CYCLES=4.
// Each row sets inputs on a falling edge and checks outputs one rising edge later.
module tb_seg_display_arbiter;

  localparam int DWELL = 4;
  localparam logic [31:0] D1 = 32'h11111111;
  localparam logic [31:0] D2 = 32'h22222222;
  localparam logic [31:0] D3 = 32'h33333333;
  localparam logic [31:0] D4 = 32'h44444444;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] src_data;
  logic         mode;
  logic [1:0]   man_sel;
  logic         hold;
  logic [31:0]  disp_data;
  logic [1:0]   disp_src;
  logic [3:0]   grant;
  logic         disp_valid;
  logic         switch_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic        mode;
    logic [1:0]  man_sel;
    logic        hold;
    logic [31:0] d0;
    logic [3:0]  grant;
    logic [31:0] data;
    logic        valid;
    logic        pulse;
  } vec_t;

  vec_t vecs[$];

  seg_display_arbiter #(.DWELL_CYCLES(DWELL), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .src_data     (src_data),
    .mode         (mode),
    .man_sel      (man_sel),
    .hold         (hold),
    .disp_data    (disp_data),
    .disp_src     (disp_src),
    .grant        (grant),
    .disp_valid   (disp_valid),
    .switch_pulse (switch_pulse)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_grant"}, -1, 32'(grant), 32'h0);
    chk({name, "_data"},  -1, disp_data, 32'h0);
    chk({name, "_src"},   -1, 32'(disp_src), 32'h0);
    chk({name, "_valid"}, -1, 32'(disp_valid), 32'h0);
    chk({name, "_pulse"}, -1, 32'(switch_pulse), 32'h0);
  endtask

  task automatic add(input int n, input logic [3:0] r, input logic m, input logic [1:0] s,
                     input logic h, input logic [31:0] d0, input logic [3:0] g,
                     input logic [31:0] d, input logic v, input logic p);
    vec_t x;
    x.req = r; x.mode = m; x.man_sel = s; x.hold = h; x.d0 = d0;
    x.grant = g; x.data = d; x.valid = v; x.pulse = p;
    for (int i = 0; i < n; i++) vecs.push_back(x);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    rst = 1'b0; req = 4'b0; mode = 1'b0; man_sel = 2'd0; hold = 1'b0;
    src_data = {D4, D3, D2, D1};

    // idle after reset
    add(3, 4'b0000, 0, 0, 0, D1, 4'b0000, 32'h0, 0, 0);
    // auto round-robin over 1011
    add(1, 4'b1011, 0, 0, 0, D1, 4'b0001, D1, 1, 1);
    add(3, 4'b1011, 0, 0, 0, D1, 4'b0001, D1, 1, 0);
    add(1, 4'b1011, 0, 0, 0, D1, 4'b0010, D2, 1, 1);
    add(3, 4'b1011, 0, 0, 0, D1, 4'b0010, D2, 1, 0);
    add(1, 4'b1011, 0, 0, 0, D1, 4'b1000, D4, 1, 1);
    add(3, 4'b1011, 0, 0, 0, D1, 4'b1000, D4, 1, 0);
    add(1, 4'b1011, 0, 0, 0, D1, 4'b0001, D1, 1, 1);
    add(1, 4'b0000, 0, 0, 0, D1, 4'b0000, 32'h0, 0, 0);
    // single requester across a dwell expiry, then drop
    add(1, 4'b0100, 0, 0, 0, D1, 4'b0100, D3, 1, 1);
    add(5, 4'b0100, 0, 0, 0, D1, 4'b0100, D3, 1, 0);
    add(1, 4'b0000, 0, 0, 0, D1, 4'b0000, 32'h0, 0, 0);
    // mid-dwell drop, then check the dwell restarted at the switch
    add(1, 4'b0010, 0, 0, 0, D1, 4'b0010, D2, 1, 1);
    add(1, 4'b1010, 0, 0, 0, D1, 4'b0010, D2, 1, 0);
    add(1, 4'b1000, 0, 0, 0, D1, 4'b1000, D4, 1, 1);
    add(3, 4'b1010, 0, 0, 0, D1, 4'b1000, D4, 1, 0);
    add(1, 4'b1010, 0, 0, 0, D1, 4'b0010, D2, 1, 1);
    add(1, 4'b0000, 0, 0, 0, D1, 4'b0000, 32'h0, 0, 0);
    // hold freezes data and grant while req drops
    add(1, 4'b0001, 0, 0, 0, 32'hDEADBEEF, 4'b0001, 32'hDEADBEEF, 1, 1);
    add(1, 4'b0001, 0, 0, 1, 32'hDEADBEEF, 4'b0001, 32'hDEADBEEF, 1, 0);
    add(2, 4'b0000, 0, 0, 1, 32'h12345678, 4'b0001, 32'hDEADBEEF, 1, 0);
    add(1, 4'b0000, 0, 0, 0, 32'h12345678, 4'b0001, 32'h12345678, 1, 0);
    add(1, 4'b0000, 0, 0, 0, 32'h12345678, 4'b0000, 32'h0, 0, 0);
    // manual mode, man_sel change, requester loss, mode toggles
    add(1, 4'b1111, 1, 2, 0, D1, 4'b0100, D3, 1, 1);
    add(5, 4'b1111, 1, 2, 0, D1, 4'b0100, D3, 1, 0);
    add(1, 4'b1111, 1, 0, 0, D1, 4'b0001, D1, 1, 1);
    add(1, 4'b1110, 1, 0, 0, D1, 4'b0000, 32'h0, 0, 0);
    add(1, 4'b1111, 1, 0, 0, D1, 4'b0001, D1, 1, 1);
    add(1, 4'b1111, 0, 0, 0, D1, 4'b0010, D2, 1, 1);
    add(1, 4'b1111, 1, 0, 0, D1, 4'b0001, D1, 1, 1);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1 chk_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req      = vecs[i].req;
      mode     = vecs[i].mode;
      man_sel  = vecs[i].man_sel;
      hold     = vecs[i].hold;
      src_data = {D4, D3, D2, vecs[i].d0};
      @(negedge clk);
      chk("grant", i, 32'(grant), 32'(vecs[i].grant));
      chk("disp_data", i, disp_data, vecs[i].data);
      chk("disp_valid", i, 32'(disp_valid), 32'(vecs[i].valid));
      chk("switch_pulse", i, 32'(switch_pulse), 32'(vecs[i].pulse));
      if (vecs[i].valid)
        chk("disp_src", i, 32'(disp_src), 32'(idx_of(vecs[i].grant)));
    end

    // reset asserted mid-SHOW takes effect without a clock edge
    #2 rst = 1'b1;
    #1 chk_zero("reset_mid_show");
    @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk_zero("reset_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
